ram_write_ctrl: RTL and testbench

- Write-side front end that sits directly upstream of the flip-flop RAM arrays (ram8 … ram16K).
- Accepts CPU write requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives the RAM's in/address/load inputs one word per cycle.
- Performs a hardware zero-fill sweep of every word after reset and on demand, so the RAM's own synchronous reset input can be tied low.

---
 rtl/ram_write_ctrl_pkg.sv | 14 +
 rtl/ram_write_ctrl_if.sv | 13 +
 rtl/ram_write_ctrl_sync_fifo.sv | 54 +++++
 rtl/ram_write_ctrl.sv | 113 +++++++++++
 tb/tb_ram_write_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_write_ctrl_pkg.sv
// Shared types for the RAM write controller: FSM states and the count-width helper.
package ram_write_ctrl_pkg;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Occupancy counters need one extra bit so "full" (== depth) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ram_write_ctrl_if.sv
// CPU-side write request handshake (valid/ready with address and data).
interface ram_write_ctrl_if #(
  parameter int BIT_WIDTH = 16,
  parameter int SEL_WIDTH = 3
);
  logic                 req_valid;
  logic                 req_ready;
  logic [SEL_WIDTH-1:0] req_addr;
  logic [BIT_WIDTH-1:0] req_data;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/ram_write_ctrl_sync_fifo.sv
// Generic synchronous FIFO; push is ignored when full, pop is ignored when empty.
module sync_fifo
  import ram_write_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(DEPTH)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign dout   = r_mem[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/ram_write_ctrl.sv
// Write front end for the flip-flop RAM arrays: buffered CPU writes plus a zero-fill sweep.
// Optional write counter output enabled by defining RAM_WRITE_CTRL_STATS_EN.
module ram_write_ctrl
  import ram_write_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  ram_write_ctrl_if.slave              req,
  input  logic                         clear_start,
  output logic                         busy,
  output logic [cnt_w(FIFO_DEPTH)-1:0] fifo_count,
  output logic [BIT_WIDTH-1:0]         ram_in,
  output logic [SEL_WIDTH-1:0]         ram_address,
  output logic                         ram_load
`ifdef RAM_WRITE_CTRL_STATS_EN
  ,
  output logic [31:0]                  wr_count
`endif
);
  typedef struct packed {
    logic [SEL_WIDTH-1:0] addr;
    logic [BIT_WIDTH-1:0] data;
  } entry_t;

  localparam int EW = $bits(entry_t);

  state_e               r_state, w_state_n;
  logic [SEL_WIDTH-1:0] r_ptr, w_ptr_n, w_addr_n;
  logic [BIT_WIDTH-1:0] w_in_n;
  logic                 w_load_n;
  logic                 w_push, w_pop, w_full, w_empty;
  entry_t               w_din, w_head;

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign req.req_ready = reset & ~w_full;
  assign w_push        = req.req_valid & req.req_ready;
  assign w_din         = '{addr: req.req_addr, data: req.req_data};
  assign w_pop         = (r_state == ST_RUN) & ~w_empty;
  assign busy          = (r_state == ST_SWEEP);

  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_addr_n  = ram_address;
    w_in_n    = ram_in;
    w_load_n  = 1'b0;
    case (r_state)
      ST_SWEEP: begin
        w_addr_n = r_ptr;
        w_in_n   = '0;
        w_load_n = 1'b1;
        w_ptr_n  = r_ptr + 1'b1;
        if (r_ptr == '1) w_state_n = ST_RUN;
      end
      ST_RUN: begin
        if (w_pop) begin
          w_addr_n = w_head.addr;
          w_in_n   = w_head.data;
          w_load_n = 1'b1;
        end
        // A pop on the same edge still lands; buffered entries drain after the sweep.
        if (clear_start) begin
          w_state_n = ST_SWEEP;
          w_ptr_n   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_SWEEP;
      r_ptr       <= '0;
      ram_address <= '0;
      ram_in      <= '0;
      ram_load    <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_ptr       <= w_ptr_n;
      ram_address <= w_addr_n;
      ram_in      <= w_in_n;
      ram_load    <= w_load_n;
    end
  end

`ifdef RAM_WRITE_CTRL_STATS_EN
  logic [31:0] r_wr_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     r_wr_count <= '0;
    else if (w_pop) r_wr_count <= r_wr_count + 32'd1;
  end

  assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_ram_write_ctrl.sv
// Bench for ram_write_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_ram_write_ctrl;
  localparam int NW = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear_start;
  logic        busy;
  logic [2:0]  fifo_count;
  logic [15:0] ram_in;
  logic [2:0]  ram_address;
  logic        ram_load;
`ifdef RAM_WRITE_CTRL_STATS_EN
  logic [31:0] wr_count;
`endif

  ram_write_ctrl_if #(.BIT_WIDTH(16), .SEL_WIDTH(3)) bus ();

  ram_write_ctrl #(.BIT_WIDTH(16), .SEL_WIDTH(3), .FIFO_DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (bus),
    .clear_start (clear_start),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .ram_in      (ram_in),
    .ram_address (ram_address),
    .ram_load    (ram_load)
`ifdef RAM_WRITE_CTRL_STATS_EN
    ,
    .wr_count    (wr_count)
`endif
  );

  always #5 clock = ~clock;

  // Downstream RAM as seen by the controller.
  logic [15:0] tb_mem [NW];
  always @(posedge clock) if (ram_load) tb_mem[ram_address] <= ram_in;

  // Transaction-level reference: pending queue in acceptance order, sweep countdown, expected memory.
  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         q[$];
  int          sweep_left;
  logic [15:0] exp_mem [NW];
  logic [2:0]  last_a;
  logic [15:0] last_d;
  bit          pend_v;
  wr_t         pend;
  int unsigned exp_wr;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    sweep_left = NW;
    last_a     = '0;
    last_d     = '0;
    pend_v     = 1'b0;
    exp_wr     = 0;
  endtask

  task automatic chk_reset_state();
    chk("rst_load",  32'(ram_load), 32'd0);
    chk("rst_addr",  32'(ram_address), 32'd0);
    chk("rst_in",    32'(ram_in), 32'd0);
    chk("rst_busy",  32'(busy), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
`ifdef RAM_WRITE_CTRL_STATS_EN
    chk("rst_wr_count", wr_count, 32'd0);
`endif
  endtask

  task automatic chk_mem();
    for (int i = 0; i < NW; i++) chk($sformatf("mem%0d", i), 32'(tb_mem[i]), 32'(exp_mem[i]));
  endtask

  // One clock: drive, check ready, advance model across the edge, check registered outputs.
  task automatic step(input logic v, input logic [2:0] a, input logic [15:0] d, input logic clr);
    bit          acc, was_run, eload;
    logic [2:0]  ea;
    logic [15:0] ed;
    wr_t         e;
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
    clear_start   = clr;
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(q.size() < 4));
    acc = v && (q.size() < 4);
    @(posedge clock);
    if (pend_v) exp_mem[pend.a] = pend.d;
    was_run = (sweep_left == 0);
    eload   = 1'b0;
    ea      = last_a;
    ed      = last_d;
    if (!was_run) begin
      eload = 1'b1;
      ea    = 3'(NW - sweep_left);
      ed    = '0;
      sweep_left--;
    end else if (q.size() > 0) begin
      e     = q.pop_front();
      eload = 1'b1;
      ea    = e.a;
      ed    = e.d;
      exp_wr++;
    end
    if (acc) begin
      e.a = a;
      e.d = d;
      q.push_back(e);
    end
    if (clr && was_run) sweep_left = NW;
    pend_v = eload;
    pend.a = ea;
    pend.d = ed;
    last_a = ea;
    last_d = ed;
    #1;
    chk("ram_load",   32'(ram_load), 32'(eload));
    chk("ram_addr",   32'(ram_address), 32'(ea));
    chk("ram_in",     32'(ram_in), 32'(ed));
    chk("busy",       32'(busy), 32'(sweep_left > 0));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
`ifdef RAM_WRITE_CTRL_STATS_EN
    chk("wr_count", wr_count, exp_wr);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 16'd0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges, held two edges, released after an edge.
  task automatic do_reset();
    #3;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    clear_start   = 1'b0;
    #1;
    chk_reset_state();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [2:0]  bp_a [6];
    logic [15:0] bp_d [6];
    int          idx;
    bit          will;

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    clear_start   = 1'b0;
    model_reset();
    for (int i = 0; i < NW; i++) exp_mem[i] = 16'hxxxx;

    #2;
    chk_reset_state();
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Power-on sweep: 8 zero writes, then one more edge for the last to land.
    idle(NW + 1);
    for (int i = 0; i < NW; i++) chk($sformatf("sweep_zero%0d", i), 32'(tb_mem[i]), 32'd0);

    // Single write latency.
    step(1'b1, 3'd5, 16'hBEEF, 1'b0);
    idle(2);
    chk("single_beef", 32'(tb_mem[5]), 32'h0000BEEF);

    // Backpressure: six held requests issued during a sweep.
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = 3'($urandom_range(0, 7));
      bp_d[i] = 16'($urandom);
    end
    step(1'b0, 3'd0, 16'd0, 1'b1);
    idx = 0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      will = (q.size() < 4);
      step(1'b1, bp_a[idx], bp_d[idx], 1'b0);
      if (will) idx++;
    end
    chk("bp_all_sent", 32'(idx), 32'd6);
    idle(8);
    chk_mem();

    // Same-address ordering: last write wins.
    step(1'b1, 3'd3, 16'd1, 1'b0);
    step(1'b1, 3'd3, 16'd2, 1'b0);
    step(1'b1, 3'd3, 16'd7, 1'b0);
    idle(3);
    chk("order_w3", 32'(tb_mem[3]), 32'd7);

    // clear_start coincident with acceptance, second clear mid-sweep ignored.
    step(1'b1, 3'd1, 16'h1111, 1'b1);
    step(1'b1, 3'd2, 16'h2222, 1'b0);
    idle(2);
    step(1'b0, 3'd0, 16'd0, 1'b1);
    idle(7);
    chk("clr_w1", 32'(tb_mem[1]), 32'h1111);
    chk("clr_w2", 32'(tb_mem[2]), 32'h2222);
    chk_mem();

    // Reset mid-drain discards buffered writes and restarts the sweep.
    step(1'b1, 3'd6, 16'hAAAA, 1'b0);
    step(1'b1, 3'd7, 16'hBBBB, 1'b0);
    step(1'b1, 3'd0, 16'hCCCC, 1'b0);
    step(1'b0, 3'd0, 16'd0, 1'b0);
    do_reset();
    idle(NW + 1);
    chk_mem();

    // Random traffic with occasional clears and one mid-run reset.
    for (int c = 0; c < 400; c++) begin
      step(1'b1 & ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 16'($urandom),
           1'b1 & ($urandom_range(0, 24) == 0));
      if (c == 200) do_reset();
    end
    idle(20);
    chk_mem();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
